// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: credit-limited fetch PC/request issue, in-order response FIFO to decode, jump flush with stale-response drop, sticky error on unsolicited rvalid
module inst_fetch_queue #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000,
  parameter int                    PC_STEP    = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable_i,
  input  logic                    jump_flag_i,
  input  logic [ADDR_WIDTH-1:0]   jump_addr_i,
  output logic                    mem_req_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [DATA_WIDTH-1:0]   out_inst_o,
  output logic [ADDR_WIDTH-1:0]   out_addr_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    err_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, resp_pc_q, resp_pc_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d, outst_q, outst_d, drop_q, drop_d;
  logic err_q, err_d;
  logic [DATA_WIDTH-1:0] inst_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic issue, resp, push, pop;
  assign mem_req_o   = enable_i & ~jump_flag_i & (({1'b0, count_q} + {1'b0, outst_q}) < (CW+1)'(DEPTH));
  assign mem_addr_o  = pc_q;
  assign out_valid_o = count_q != '0;
  assign out_inst_o  = inst_q[rd_q];
  assign out_addr_o  = addr_q[rd_q];
  assign count_o     = count_q;
  assign err_o       = err_q;
  assign issue = mem_req_o & mem_gnt_i;
  assign resp  = mem_rvalid_i & (outst_q != '0);
  assign push  = resp & (drop_q == '0) & ~jump_flag_i;
  assign pop   = out_valid_o & out_ready_i;
  always_comb begin
    pc_d      = jump_flag_i ? jump_addr_i : pc_q + (issue ? STEP : '0);
    resp_pc_d = jump_flag_i ? jump_addr_i : resp_pc_q + (push ? STEP : '0);
    rd_d      = jump_flag_i ? '0 : rd_q + PW'(pop);
    wr_d      = jump_flag_i ? '0 : wr_q + PW'(push);
    count_d   = jump_flag_i ? '0 : count_q + CW'(push) - CW'(pop);
    outst_d   = outst_q + CW'(issue) - CW'(resp);
    drop_d    = jump_flag_i ? outst_q - CW'(resp) : drop_q - CW'(resp & (drop_q != '0));
    err_d     = err_q | (mem_rvalid_i & (outst_q == '0));
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      rd_q      <= '0;
      wr_q      <= '0;
      count_q   <= '0;
      outst_q   <= '0;
      drop_q    <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      count_q   <= count_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
      err_q     <= err_d;
      if (push) begin
        inst_q[wr_q] <= mem_rdata_i;
        addr_q[wr_q] <= resp_pc_q;
      end
    end
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: random and directed stimulus against a queue-based model of fetch, flush and decode delivery
module tb_inst_fetch_queue;
  localparam int D = 4;
  localparam logic [31:0] RPC = 32'h8000_0000;
  logic clk = 0, reset_n = 0;
  logic enable_i = 0, jump_flag_i = 0, mem_gnt_i = 0, mem_rvalid_i = 0, out_ready_i = 0;
  logic [31:0] jump_addr_i = '0, mem_rdata_i = '0;
  logic mem_req_o, out_valid_o, err_o;
  logic [31:0] mem_addr_o, out_inst_o, out_addr_o;
  logic [2:0] count_o;
  inst_fetch_queue #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(D), .RESET_PC(RPC), .PC_STEP(4)) dut (
    .clk(clk), .reset_n(reset_n), .enable_i(enable_i), .jump_flag_i(jump_flag_i),
    .jump_addr_i(jump_addr_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_inst_o(out_inst_o),
    .out_addr_o(out_addr_o), .count_o(count_o), .err_o(err_o));
  always #5 clk = ~clk;
  typedef struct {logic [31:0] a; logic [31:0] d; bit stale;} ent_t;
  ent_t infl[$];
  ent_t fifo[$];
  logic [31:0] m_pc;
  bit m_err;
  int errors = 0, checks = 0;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    infl.delete();
    fifo.delete();
    m_pc = RPC;
    m_err = 0;
  endtask
  task automatic cycle(bit en, bit jmp, logic [31:0] ja, bit gnt, bit rv, bit rdy);
    bit req;
    ent_t e;
    enable_i = en;
    jump_flag_i = jmp;
    jump_addr_i = ja;
    mem_gnt_i = gnt;
    mem_rvalid_i = rv && infl.size() > 0;
    mem_rdata_i = mem_rvalid_i ? infl[0].d : $urandom;
    out_ready_i = rdy;
    #1;
    req = en && !jmp && (fifo.size() + infl.size() < D);
    chk("mem_req", mem_req_o, req);
    chk("mem_addr", mem_addr_o, m_pc);
    chk("out_valid", out_valid_o, fifo.size() != 0);
    chk("count", count_o, fifo.size());
    chk("err", err_o, m_err);
    if (fifo.size() != 0) begin
      chk("out_addr", out_addr_o, fifo[0].a);
      chk("out_inst", out_inst_o, fifo[0].d);
    end
    if (rdy && fifo.size() != 0) void'(fifo.pop_front());
    if (mem_rvalid_i) begin
      e = infl.pop_front();
      if (!e.stale && !jmp) fifo.push_back(e);
    end
    if (jmp) begin
      fifo.delete();
      foreach (infl[i]) infl[i].stale = 1;
      m_pc = ja;
    end
    if (req && gnt) begin
      e.a = m_pc;
      e.d = $urandom;
      e.stale = 0;
      infl.push_back(e);
      m_pc += 4;
    end
    @(negedge clk);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int cnt;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_count", count_o, 0);
    chk("rst_valid", out_valid_o, 0);
    chk("rst_addr", mem_addr_o, RPC);
    chk("rst_req", mem_req_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_inst", out_inst_o, 0);
    @(negedge clk);
    reset_n = 1;
    repeat (20) cycle(1, 0, 0, 1, 1, 1);
    repeat (8) cycle(1, 0, 0, 1, 1, 0);
    cycle(1, 0, 0, 1, 1, 1);
    repeat (3) cycle(1, 0, 0, 1, 1, 0);
    repeat (8) cycle(0, 0, 0, 0, 1, 1);
    repeat (2) cycle(1, 0, 0, 1, 0, 0);
    repeat (2) cycle(1, 0, 0, 0, 1, 0);
    repeat (2) cycle(1, 0, 0, 1, 0, 0);
    cycle(1, 1, 32'h100, 1, 0, 0);
    repeat (12) cycle(1, 0, 0, 1, 1, 1);
    repeat (2) cycle(1, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 1, 0);
    cycle(1, 1, 32'h200, 1, 1, 1);
    repeat (12) cycle(1, 0, 0, 1, 1, 1);
    cycle(1, 1, 32'hFFFF_FFF8, 1, 0, 1);
    repeat (12) cycle(1, 0, 0, 1, 1, 1);
    repeat (3000) begin
      bit jmp;
      logic [31:0] ja;
      jmp = $urandom_range(0, 99) < 5;
      ja = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      cycle($urandom_range(0, 9) != 0, jmp, ja, $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7);
    end
    repeat (10) cycle(0, 0, 0, 0, 1, 0);
    cnt = fifo.size();
    enable_i = 0;
    jump_flag_i = 0;
    mem_gnt_i = 0;
    out_ready_i = 0;
    mem_rvalid_i = 1;
    mem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_rvalid_i = 0;
    m_err = 1;
    #1;
    chk("err_set", err_o, 1);
    chk("err_count", count_o, cnt);
    @(negedge clk);
    repeat (20) cycle(1, 0, 0, 1, 1, 1);
    repeat (10) cycle(1, 0, 0, 1, 1, 0);
    #3;
    reset_n = 0;
    enable_i = 0;
    #1;
    chk("arst_count", count_o, 0);
    chk("arst_valid", out_valid_o, 0);
    chk("arst_addr", mem_addr_o, RPC);
    chk("arst_err", err_o, 0);
    chk("arst_req", mem_req_o, 0);
    chk("arst_inst", out_inst_o, 0);
    chk("arst_oaddr", out_addr_o, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1;
    repeat (30) cycle(1, 0, 0, 1, 1, 1);
    repeat (500) cycle($urandom_range(0, 9) != 0, $urandom_range(0, 99) < 5, $urandom & 32'hFFFF_FFFC,
                       $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
